// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encoding and
// requester (grant) identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  // The requester that is not g; used to hand priority over after a contested grant.
  function automatic gnt_t other_gnt(input gnt_t g);
    return (g == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker. With a single requester it grants that one and
// leaves priority alone; with both it grants the prioritised one and passes
// priority to the other. With no requester the grant output is don't-care
// (reported as fetch) and priority is unchanged.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  gnt_t prio,
  output gnt_t gnt,
  output gnt_t prio_next
);

  // Pick the winner and the priority to use for the next contested grant.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no path leaves
    // an output unassigned and no latch is inferred.
    gnt       = GNT_FETCH;
    prio_next = prio;
    if (f_req && d_req) begin
      gnt       = prio;
      prio_next = other_gnt(prio);
    end else if (d_req) begin
      gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. A request
// seen in IDLE is registered onto the memory port and held until m_ack; the
// winner then gets a one-cycle ack (with read data for fetches and loads) in
// DONE before the arbiter returns to IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // instruction fetch requester
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic [DATA_W-1:0]   f_rdata,
  output logic                f_ack,
  // load/store requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  // memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_mask,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                busy
);

  state_t state, state_next;
  gnt_t   prio, prio_next, pick;
  logic   grant;     // a new transaction is accepted this cycle
  logic   complete;  // the memory finishes the current transaction this cycle

  rr_pick2 u_pick (
    .f_req     (f_req),
    .d_req     (d_req),
    .prio      (prio),
    .gnt       (pick),
    .prio_next (prio_next)
  );

  // Next-state logic: requests are only looked at in IDLE and m_ack only in
  // FETCH/DATA, so stale acks and requests held through DONE are ignored.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (f_req || d_req) begin
          grant      = 1'b1;
          state_next = (pick == GNT_FETCH) ? FETCH : DATA;
        end
      end
      FETCH, DATA: begin
        if (m_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and round-robin priority registers; priority only moves on a grant.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= IDLE;
      prio  <= GNT_FETCH;
    end else begin
      state <= state_next;
      if (grant) prio <= prio_next;
    end
  end

  // Memory-port registers: loaded from the winner on grant, then frozen until
  // the memory acknowledges; only m_req drops on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_mask  <= '0;
    end else if (grant) begin
      m_req <= 1'b1;
      if (pick == GNT_FETCH) begin
        m_we    <= 1'b0;
        m_addr  <= f_addr;
        m_wdata <= '0;
        m_mask  <= '1;
      end else begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_mask  <= d_mask;
      end
    end else if (complete) begin
      m_req <= 1'b0;
    end
  end

  // Completion: one-cycle ack to the winner; read data is captured for fetches
  // and loads only, so a store leaves d_rdata holding the last load result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      if (complete) begin
        if (state == FETCH) begin
          f_ack   <= 1'b1;
          f_rdata <= m_rdata;
        end else begin
          d_ack <= 1'b1;
          if (!m_we) d_rdata <= m_rdata;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions,
// hand-written multi-cycle sequences, then randomized traffic checked against
// a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req, f_ack, d_req, d_we, d_ack;
  logic        m_req, m_we, m_ack, busy;
  logic [31:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  d_mask, m_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_ack   (f_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_mask  (d_mask),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_mask  (m_mask),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .busy    (busy)
  );

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          waits;
    logic [31:0] mem_rdata;
    logic        exp_we;
    logic [3:0]  exp_mask;
    logic [31:0] exp_f_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".m_req"}, 32'(m_req), 32'd0);
    check({tag, ".f_ack"}, 32'(f_ack), 32'd0);
    check({tag, ".d_ack"}, 32'(d_ack), 32'd0);
    check({tag, ".busy"},  32'(busy),  32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, ".m_we"},    32'(m_we),   32'd0);
    check({tag, ".m_addr"},  m_addr,      32'd0);
    check({tag, ".m_wdata"}, m_wdata,     32'd0);
    check({tag, ".m_mask"},  32'(m_mask), 32'd0);
    check({tag, ".f_rdata"}, f_rdata,     32'd0);
    check({tag, ".d_rdata"}, d_rdata,     32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = '0;
    m_ack = 1'b0; m_rdata = '0;
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  // One complete transaction from a table row, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_mask = v.mask;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
      d_we = 1'b1; d_mask = 4'h0; d_wdata = 32'hFFFF_FFFF;
    end
    step();
    for (int c = 0; c <= v.waits; c++) begin
      tag = $sformatf("v%0d.c%0d", idx, c);
      check({tag, ".m_req"},  32'(m_req),  32'd1);
      check({tag, ".m_addr"}, m_addr,      v.addr);
      check({tag, ".m_we"},   32'(m_we),   32'(v.exp_we));
      check({tag, ".m_mask"}, 32'(m_mask), 32'(v.exp_mask));
      if (v.is_data) check({tag, ".m_wdata"}, m_wdata, v.wdata);
      check({tag, ".f_ack"},  32'(f_ack),  32'd0);
      check({tag, ".d_ack"},  32'(d_ack),  32'd0);
      check({tag, ".busy"},   32'(busy),   32'd1);
      m_ack   = (c == v.waits);
      m_rdata = (c == v.waits) ? v.mem_rdata : 32'h0BAD_F00D;
      step();
    end
    tag = $sformatf("v%0d.ack", idx);
    check({tag, ".f_ack"},   32'(f_ack), 32'(!v.is_data));
    check({tag, ".d_ack"},   32'(d_ack), 32'(v.is_data));
    check({tag, ".m_req"},   32'(m_req), 32'd0);
    check({tag, ".f_rdata"}, f_rdata,    v.exp_f_rdata);
    check({tag, ".d_rdata"}, d_rdata,    v.exp_d_rdata);
    f_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();
    check_quiet($sformatf("v%0d.idle", idx));
  endtask

  // Transaction-level reference model state for the randomized phase.
  logic        s_f, s_d, s_dwe, s_mack;
  logic [31:0] s_faddr, s_daddr, s_dwdata, s_mrdata;
  logic [3:0]  s_dmask;
  int          phase;   // 0 = waiting for a request, 1 = on the memory port, 2 = acked
  logic        prio_m, win, e_we, e_fa, e_da, exp_d, granted_now;
  logic [31:0] e_addr, e_wdata, e_fr, e_dr;
  logic [3:0]  e_mask;
  int          wcnt;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF,
                1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'h3, 3, 32'hBAD0_BAD0,
                1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h1111_1111,
                1'b0, 4'hF, 32'h1111_1111, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 2, 32'hA5A5_A5A5,
                1'b0, 4'hF, 32'h1111_1111, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0408, 32'hCAFE_F00D, 4'h8, 0, 32'h7777_7777,
                1'b1, 4'h8, 32'h1111_1111, 32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2, 32'h0000_0000,
                1'b0, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Both requesters permanently asking: grants alternate fetch, data, fetch, data.
    do_reset();
    f_addr = 32'h0000_A000; d_addr = 32'h0000_B000; d_we = 1'b0; d_mask = 4'hF;
    f_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_d = g[0];
      step();
      check($sformatf("rr%0d.m_req", g),  32'(m_req), 32'd1);
      check($sformatf("rr%0d.m_addr", g), m_addr, exp_d ? 32'h0000_B000 : 32'h0000_A000);
      m_ack = 1'b1; m_rdata = 32'h1000 + 32'(g);
      step();
      check($sformatf("rr%0d.f_ack", g), 32'(f_ack), 32'(!exp_d));
      check($sformatf("rr%0d.d_ack", g), 32'(d_ack), 32'(exp_d));
      m_ack = 1'b0;
      if (exp_d) d_req = 1'b0; else f_req = 1'b0;
      step();
      check($sformatf("rr%0d.f_ack2", g), 32'(f_ack), 32'd0);
      check($sformatf("rr%0d.d_ack2", g), 32'(d_ack), 32'd0);
      check($sformatf("rr%0d.busy", g),   32'(busy),  32'd0);
      f_req = 1'b1; d_req = 1'b1;
    end
    f_req = 1'b0; d_req = 1'b0;
    step();
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    step();

    // Fetcher holds f_req through its ack cycle: no second transaction.
    f_req = 1'b1; f_addr = 32'h0000_0C00;
    step();
    check("hold.m_req", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h2222_2222;
    step();
    check("hold.f_ack",   32'(f_ack), 32'd1);
    check("hold.f_rdata", f_rdata,    32'h2222_2222);
    m_ack = 1'b0;
    step();
    check_quiet("hold.done");
    f_req = 1'b0;
    step();
    check_quiet("hold.idle1");
    step();
    check_quiet("hold.idle2");

    // Reset while a load is on the port and priority points at data.
    do_reset();
    f_addr = 32'h0000_0600; d_addr = 32'h0000_0500; d_we = 1'b0; d_mask = 4'hF;
    f_req = 1'b1; d_req = 1'b1;
    step();
    check("rst.first_addr", m_addr, 32'h0000_0600);
    m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
    step();
    check("rst.f_ack", 32'(f_ack), 32'd1);
    f_req = 1'b0; m_ack = 1'b0;
    step();
    step();
    check("rst.d_m_req",  32'(m_req), 32'd1);
    check("rst.d_m_addr", m_addr,     32'h0000_0500);
    reset_n = 1'b0; d_req = 1'b0;
    step();
    check_all_zero("rst.abort");
    reset_n = 1'b1; m_ack = 1'b1; m_rdata = 32'h5555_5555;
    step();
    check_all_zero("rst.late1");
    step();
    check_all_zero("rst.late2");
    m_ack = 1'b0; f_req = 1'b1; d_req = 1'b1;
    step();
    check("rst.prio_addr", m_addr, 32'h0000_0600);
    m_ack = 1'b1; m_rdata = 32'h3333_3333;
    step();
    check("rst.prio_f_ack", 32'(f_ack), 32'd1);
    check("rst.prio_d_ack", 32'(d_ack), 32'd0);
    f_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();

    // Randomized traffic against the reference model.
    do_reset();
    phase = 0; prio_m = 1'b0; win = 1'b0; e_fr = '0; e_dr = '0; wcnt = 0;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_mask = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_f = f_req; s_d = d_req; s_faddr = f_addr; s_daddr = d_addr;
      s_dwe = d_we; s_dwdata = d_wdata; s_dmask = d_mask;
      s_mack = m_ack; s_mrdata = m_rdata;
      step();
      e_fa = 1'b0; e_da = 1'b0; granted_now = 1'b0;
      if (phase == 0) begin
        if (s_f || s_d) begin
          if (s_f && s_d) begin
            win = prio_m;
            prio_m = ~prio_m;
          end else begin
            win = s_d;
          end
          if (!win) begin
            e_addr = s_faddr; e_we = 1'b0; e_mask = 4'hF; e_wdata = '0;
          end else begin
            e_addr = s_daddr; e_we = s_dwe; e_mask = s_dmask; e_wdata = s_dwdata;
          end
          phase = 1;
          granted_now = 1'b1;
        end
      end else if (phase == 1) begin
        if (s_mack) begin
          phase = 2;
          if (!win) begin
            e_fa = 1'b1; e_fr = s_mrdata;
          end else begin
            e_da = 1'b1;
            if (!e_we) e_dr = s_mrdata;
          end
        end
      end else begin
        phase = 0;
      end

      check($sformatf("r%0d.m_req", cyc),   32'(m_req), 32'(phase == 1));
      check($sformatf("r%0d.busy", cyc),    32'(busy),  32'(phase != 0));
      check($sformatf("r%0d.f_ack", cyc),   32'(f_ack), 32'(e_fa));
      check($sformatf("r%0d.d_ack", cyc),   32'(d_ack), 32'(e_da));
      check($sformatf("r%0d.f_rdata", cyc), f_rdata,    e_fr);
      check($sformatf("r%0d.d_rdata", cyc), d_rdata,    e_dr);
      if (phase == 1) begin
        check($sformatf("r%0d.m_addr", cyc), m_addr,      e_addr);
        check($sformatf("r%0d.m_we", cyc),   32'(m_we),   32'(e_we));
        check($sformatf("r%0d.m_mask", cyc), 32'(m_mask), 32'(e_mask));
        if (win) check($sformatf("r%0d.m_wdata", cyc), m_wdata, e_wdata);
      end

      // Requesters: drop on ack, otherwise occasionally start a new request.
      if (e_fa) f_req = 1'b0;
      else if (!f_req && $urandom_range(2) == 0) begin
        f_req = 1'b1; f_addr = $urandom;
      end
      if (e_da) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom);
        d_wdata = $urandom; d_mask = 4'($urandom);
      end
      // While a transaction is in flight, wiggle payloads: they must not be re-sampled.
      if (phase == 1 && $urandom_range(3) == 0) begin
        f_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_mask = 4'($urandom); d_we = 1'($urandom);
      end
      // Memory: 0-3 wait states per transaction, stray acks when idle or done.
      if (phase == 1) begin
        if (granted_now) wcnt = $urandom_range(3);
        if (wcnt == 0) begin
          m_ack = 1'b1; m_rdata = $urandom;
        end else begin
          m_ack = 1'b0; m_rdata = $urandom; wcnt--;
        end
      end else begin
        m_ack = ($urandom_range(3) == 0);
        m_rdata = $urandom;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
